ifm_bank_fifo: RTL and testbench
================================

// Module: ifm_bank_fifo
// PURPOSE
//  N-bank IFM buffer; successor to the two-FIFO ping-pong IFM buffer.
//  Sits between the DMA/IFM loader and the systolic array IFM input.
//  Banks fill and drain in round-robin order; bank selection is internal, with no external mux/demux.
//  Adds per-bank occupancy and state, variable-length tiles (wr_last), and rewind for IFM reuse across weight groups.
// PARAMETERS
//  DATA_WIDTH  16    width of one IFM word
//  DEPTH       4608  words per bank
//  NUM_BANKS   2     bank count, >=2
//  BANK_W      $clog2(NUM_BANKS), local: bank index width
//  CNT_W       $clog2(DEPTH+1), local: occupancy/pointer width
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-high
//  wr_valid      in   1           write request
//  wr_data       in   DATA_WIDTH  write word
//  wr_last       in   1           qualifies wr_valid: final word of tile
//  wr_ready      out  1           write bank can accept
//  wr_bank       out  BANK_W      bank currently filled
//  rd_en         in   1           read request
//  rd_rewind     in   1           restart reading current bank at word 0
//  rd_release    in   1           current bank consumed; free it
//  rd_bank_rdy   out  1           read bank holds a closed tile
//  rd_done       out  1           all words of read bank read once since last rewind
//  rd_bank       out  BANK_W      bank currently read
//  rd_len        out  CNT_W       length of tile in read bank
//  rd_data       out  DATA_WIDTH  read word
//  rd_valid      out  1           rd_data valid
// BEHAVIOUR
//  - Per-bank state FREE -> FILL -> READY -> READ -> FREE; per-bank len[CNT_W].
//  - Reset: all banks FREE, len=0, wr_bank=rd_bank=0, pointers=0, rd_data=0, rd_valid=0.
//    Reset mid-operation discards all contents.
//  - wr_ready = state[wr_bank] is FREE or FILL.
//  - Write accepted on wr_valid & wr_ready: mem[wr_bank][wptr] <= wr_data; wptr++; FREE->FILL.
//  - Bank close: on an accepted write with wr_last=1, or when wptr reaches DEPTH-1.
//    len <= wptr+1; state -> READY; wptr <= 0; wr_bank <= (wr_bank+1)%NUM_BANKS on the next cycle.
//  - wr_valid while wr_ready=0: ignored; no state change and no data loss tracking. The source must honour wr_ready.
//  - rd_bank_rdy = state[rd_bank] is READY or READ.
//  - rd_done = rd_bank_rdy & (rptr == len[rd_bank]).
//  - Read accepted on rd_en & rd_bank_rdy & !rd_done & !rd_release.
//    rd_data <= mem[rd_bank][rptr]; rptr++; READY->READ.
//  - Read latency: exactly 1 cycle. rd_valid=1 on the cycle after each accepted read, else 0.
//    rd_data holds its last value while rd_valid=0.
//  - rd_en with rd_done or !rd_bank_rdy: ignored, rd_valid=0.
//  - rd_rewind (rd_bank_rdy=1): rptr <= 0; state and len unchanged.
//    With rd_en in the same cycle, the read uses the old rptr, then rptr <= 0.
//  - rd_release (rd_bank_rdy=1): state -> FREE; len <= 0; rptr <= 0; rd_bank <= (rd_bank+1)%NUM_BANKS.
//    Priority: release > rewind > read. A same-cycle rd_en is dropped.
//    rd_release with rd_bank_rdy=0 is ignored.
//  - Same-cycle write to wr_bank and release of rd_bank are independent; they are always different banks.
//    A bank freed this cycle is writable next cycle.
//  - All NUM_BANKS banks READY/READ -> wr_ready=0 until a release.
//  - Memory: one write port and one registered read port per bank. No read-during-write hazard, since a bank being read is never written.
// TESTING
//  1. Reset, write 8 words 1..8 with wr_last on 8 -> bank0 READY, len=8, wr_bank=1.
//     Read 8 -> rd_data 1..8, each 1 cycle after rd_en; then rd_done=1.
//  2. Rewind: after T1, pulse rd_rewind, read 8 again -> 1..8 again; release -> rd_bank=1, bank0 FREE.
//  3. Full fill: DEPTH=16, NUM_BANKS=2, write 32 words, no wr_last.
//     -> both banks close at len=16; wr_ready=0 on cycle 33 until first release, then 1 next cycle.
//  4. Concurrency: stream writes into bank1 while reading bank0 every cycle.
//     -> no stall; rd_data sequence intact; wr_bank wraps to 0 after release.
//  5. Same-cycle rd_en+rd_release -> read dropped, rd_valid=0 next cycle, bank freed.
//     rd_en+rd_rewind at rptr=5 -> word 5 returned, rptr=0.
//  6. Assert rst mid-read with 3 of 8 words read -> all outputs to reset values in the same cycle.
//     After release: wr_ready=1, rd_bank_rdy=0.

Source files
------------

// File: rtl/ifm_bank_fifo.sv
// N-bank IFM buffer: banks fill and drain round-robin; supports variable-length tiles and rewind.
// Read latency 1 cycle; wr_ready drops while the current write bank still holds an unreleased tile.
module ifm_bank_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4608,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic [BANK_W-1:0]     wr_bank,
  input  logic                  rd_en,
  input  logic                  rd_rewind,
  input  logic                  rd_release,
  output logic                  rd_bank_rdy,
  output logic                  rd_done,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [CNT_W-1:0]      rd_len,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILL,
    BANK_READY,
    BANK_READ
  } bank_state_e;

  bank_state_e           st_q  [NUM_BANKS];
  bank_state_e           st_d  [NUM_BANKS];
  logic [CNT_W-1:0]      len_q [NUM_BANKS];
  logic [CNT_W-1:0]      len_d [NUM_BANKS];
  logic [CNT_W-1:0]      wptr_q, wptr_d;
  logic [CNT_W-1:0]      rptr_q, rptr_d;
  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]     rd_bank_q, rd_bank_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_seen_q, rd_seen_d;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic wr_fire, wr_close;
  logic rel_fire, rwd_fire, rd_fire;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  assign wr_ready    = (st_q[wr_bank_q] == BANK_FREE) || (st_q[wr_bank_q] == BANK_FILL);
  assign rd_bank_rdy = (st_q[rd_bank_q] == BANK_READY) || (st_q[rd_bank_q] == BANK_READ);
  assign rd_done     = rd_bank_rdy && (rptr_q == len_q[rd_bank_q]);

  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || (wptr_q == CNT_W'(DEPTH - 1)));
  assign rel_fire = rd_release && rd_bank_rdy;
  assign rwd_fire = rd_rewind && rd_bank_rdy && !rel_fire;
  // A same-cycle release always wins, so the read is dropped even though the bank is ready.
  assign rd_fire  = rd_en && rd_bank_rdy && !rd_done && !rd_release;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      st_d[b]  = st_q[b];
      len_d[b] = len_q[b];
    end
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_fire;
    rd_seen_d  = rd_seen_q || rd_fire;

    if (wr_fire) begin
      if (wr_close) begin
        st_d[wr_bank_q]  = BANK_READY;
        len_d[wr_bank_q] = wptr_q + CNT_W'(1);
        wptr_d           = '0;
        wr_bank_d        = next_bank(wr_bank_q);
      end else begin
        st_d[wr_bank_q] = BANK_FILL;
        wptr_d          = wptr_q + CNT_W'(1);
      end
    end

    // Write and read banks never coincide while both are active, so these updates are disjoint.
    if (rel_fire) begin
      st_d[rd_bank_q]  = BANK_FREE;
      len_d[rd_bank_q] = '0;
      rptr_d           = '0;
      rd_bank_d        = next_bank(rd_bank_q);
    end else begin
      if (rd_fire) begin
        rptr_d = rptr_q + CNT_W'(1);
        if (st_q[rd_bank_q] == BANK_READY) begin
          st_d[rd_bank_q] = BANK_READ;
        end
      end
      if (rwd_fire) begin
        rptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= BANK_FREE;
        len_q[b] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= st_d[b];
        len_q[b] <= len_d[b];
      end
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  // Storage is left unreset so it can map onto RAM; rd_seen_q masks the stale read word after reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wptr_q[ADDR_W-1:0]] <= wr_data;
    end
    if (rd_fire) begin
      rd_word <= mem[rd_bank_q][rptr_q[ADDR_W-1:0]];
    end
  end

  assign rd_data  = rd_seen_q ? rd_word : '0;
  assign rd_valid = rd_valid_q;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign rd_len   = len_q[rd_bank_q];

endmodule

// File: tb/tb_ifm_bank_fifo.sv
// Bench for ifm_bank_fifo: directed scenarios plus randomized traffic against a tile-level model.
module tb_ifm_bank_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int NB    = 2;
  localparam int BW    = 1;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic          rd_en = 1'b0;
  logic          rd_rewind = 1'b0;
  logic          rd_release = 1'b0;
  logic          rd_bank_rdy;
  logic          rd_done;
  logic [BW-1:0] rd_bank;
  logic [CW-1:0] rd_len;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  always #5 clk = ~clk;

  ifm_bank_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_rewind(rd_rewind), .rd_release(rd_release),
    .rd_bank_rdy(rd_bank_rdy), .rd_done(rd_done), .rd_bank(rd_bank),
    .rd_len(rd_len), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  int total = 0;
  int bad   = 0;

  // Tile-level model: each bank is a list of words plus a "closed" flag.
  logic [DW-1:0] mdat [NB][DEPTH];
  int            msize [NB];
  bit            mclosed [NB];
  int            mwb, mrb, mrpos;
  bit            exp_rv;
  logic [DW-1:0] exp_rd;

  localparam logic [26:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0};

  function automatic void m_reset();
    for (int b = 0; b < NB; b++) begin
      msize[b]   = 0;
      mclosed[b] = 1'b0;
    end
    mwb = 0; mrb = 0; mrpos = 0;
    exp_rv = 1'b0; exp_rd = '0;
  endfunction

  function automatic bit m_done();
    return mclosed[mrb] && (mrpos == msize[mrb]);
  endfunction

  function automatic logic [26:0] obs_vec();
    return {wr_ready, rd_bank_rdy, rd_done, wr_bank, rd_bank, rd_len, rd_valid, rd_data};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {!mclosed[mwb], mclosed[mrb], m_done(), BW'(mwb), BW'(mrb),
            mclosed[mrb] ? CW'(msize[mrb]) : CW'(0), exp_rv, exp_rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model advances by the rules for that cycle.
  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit wl,
                       input bit re, input bit rw, input bit rl);
    bit wfire, rdy, done;
    wr_valid = wv; wr_data = wd; wr_last = wl;
    rd_en = re; rd_rewind = rw; rd_release = rl;
    wfire = wv && !mclosed[mwb];
    rdy   = mclosed[mrb];
    done  = m_done();
    tick();
    exp_rv = 1'b0;
    if (wfire) begin
      mdat[mwb][msize[mwb]] = wd;
      msize[mwb]++;
      if (wl || msize[mwb] == DEPTH) begin
        mclosed[mwb] = 1'b1;
        mwb = (mwb + 1) % NB;
      end
    end
    if (rl && rdy) begin
      msize[mrb] = 0; mclosed[mrb] = 1'b0; mrpos = 0;
      mrb = (mrb + 1) % NB;
    end else begin
      if (re && rdy && !done) begin
        exp_rv = 1'b1;
        exp_rd = mdat[mrb][mrpos];
        mrpos++;
      end
      if (rw && rdy) mrpos = 0;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    rd_en = 1'b0; rd_rewind = 1'b0; rd_release = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (obs_vec() !== RESET_VEC) begin
      bad++; $display("FAIL reset_held got=%h want=%h", obs_vec(), RESET_VEC);
    end
    rst = 1'b0;
    m_reset();
    tick();
    total++;
    if (obs_vec() !== RESET_VEC) begin
      bad++; $display("FAIL reset_released got=%h want=%h", obs_vec(), RESET_VEC);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), i == 8, 1'b0, 1'b0, 1'b0);
    total++;
    if ({rd_bank_rdy, rd_len, wr_bank, rd_done} !== {1'b1, 5'd8, 1'b1, 1'b0}) begin
      bad++; $display("FAIL basic_close got rdy=%b len=%0d wb=%0d done=%b want 1 8 1 0",
                      rd_bank_rdy, rd_len, wr_bank, rd_done);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        bad++; $display("FAIL basic_read[%0d] got v=%b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, i);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({rd_done, rd_valid, rd_data} !== {1'b1, 1'b0, 16'd8}) begin
      bad++; $display("FAIL basic_done got done=%b v=%b d=%0d want 1 0 8", rd_done, rd_valid, rd_data);
    end
  endtask

  task automatic test_rewind();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({rd_done, rd_bank_rdy, rd_valid} !== 3'b010) begin
      bad++; $display("FAIL rewind_state got done=%b rdy=%b v=%b want 0 1 0", rd_done, rd_bank_rdy, rd_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        bad++; $display("FAIL rewind_read[%0d] got v=%b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, i);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({rd_bank, rd_bank_rdy, rd_len, wr_ready} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL rewind_release got rb=%0d rdy=%b len=%0d wrdy=%b want 1 0 0 1",
                      rd_bank, rd_bank_rdy, rd_len, wr_ready);
    end
  endtask

  task automatic test_full_fill();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      total++;
      if (wr_ready !== 1'b1) begin
        bad++; $display("FAIL fill_ready[%0d] got=%b want=1", i, wr_ready);
      end
      drive(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if ({wr_ready, wr_bank, rd_bank_rdy, rd_len} !== {1'b0, 1'b1, 1'b1, 5'd16}) begin
      bad++; $display("FAIL fill_full got wrdy=%b wb=%0d rdy=%b len=%0d want 0 1 1 16",
                      wr_ready, wr_bank, rd_bank_rdy, rd_len);
    end
    drive(1'b1, 16'hdead, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_vec() !== exp_vec() || wr_ready !== 1'b0) begin
      bad++; $display("FAIL fill_ignored got=%h want=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
        bad++; $display("FAIL fill_read[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp_rd);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({wr_ready, rd_bank, rd_len} !== {1'b1, 1'b0, 5'd16}) begin
      bad++; $display("FAIL fill_release got wrdy=%b rb=%0d len=%0d want 1 0 16", wr_ready, rd_bank, rd_len);
    end
  endtask

  task automatic test_concurrency();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 10) begin
        total++;
        if (wr_ready !== 1'b1) begin
          bad++; $display("FAIL conc_wready[%0d] got=%b want=1", i, wr_ready);
        end
      end
      drive(i < 10, DW'(16'h200 + i), i == 9, 1'b1, 1'b0, 1'b0);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
        bad++; $display("FAIL conc_read[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp_rd);
      end
    end
    total++;
    if ({wr_bank, wr_ready, rd_done} !== 3'b001) begin
      bad++; $display("FAIL conc_end got wb=%0d wrdy=%b done=%b want 0 0 1", wr_bank, wr_ready, rd_done);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({wr_bank, wr_ready, rd_bank, rd_len} !== {1'b0, 1'b1, 1'b1, 5'd10}) begin
      bad++; $display("FAIL conc_release got wb=%0d wrdy=%b rb=%0d len=%0d want 0 1 1 10",
                      wr_bank, wr_ready, rd_bank, rd_len);
    end
  endtask

  task automatic test_release_rewind();
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h205) begin
      bad++; $display("FAIL rwd_read got v=%b d=%h want v=1 d=0205", rd_valid, rd_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h200) begin
      bad++; $display("FAIL rwd_restart got v=%b d=%h want v=1 d=0200", rd_valid, rd_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if ({rd_valid, rd_data, rd_bank, rd_bank_rdy, wr_ready} !== {1'b0, 16'h200, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rel_drop got v=%b d=%h rb=%0d rdy=%b wrdy=%b want 0 0200 0 0 1",
                      rd_valid, rd_data, rd_bank, rd_bank_rdy, wr_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(16'h300 + i), i == 7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h302 || wr_bank !== 1'b1) begin
      bad++; $display("FAIL mid_pre got v=%b d=%h wb=%0d want 1 0302 1", rd_valid, rd_data, wr_bank);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs_vec() !== RESET_VEC) begin
      bad++; $display("FAIL mid_async got=%h want=%h", obs_vec(), RESET_VEC);
    end
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    total++;
    if ({wr_ready, rd_bank_rdy} !== 2'b10) begin
      bad++; $display("FAIL mid_after got wrdy=%b rdy=%b want 1 0", wr_ready, rd_bank_rdy);
    end
  endtask

  task automatic test_random();
    bit wv, wl, re, rw, rl;
    for (int c = 0; c < 3000; c++) begin
      wv = ($urandom_range(0, 9) < 7);
      wl = ($urandom_range(0, 9) == 0);
      re = ($urandom_range(0, 9) < 7);
      rw = ($urandom_range(0, 29) == 0);
      rl = m_done() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      drive(wv, DW'($urandom), wl, re, rw, rl);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_rewind();
    test_full_fill();
    test_concurrency();
    test_release_rewind();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
